// File: rtl/mandel_pkg.sv
// Shared types and fixed-point helpers for the Mandelbrot escape-time engine.
// Coordinates and z use signed Q4.23 (DATA_W bits, FRAC_W fractional).
package mandel_pkg;

   localparam int unsigned DATA_W = 27;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned MAG_W  = PROD_W - FRAC_W + 1;

   localparam logic signed [MAG_W-1:0] FOUR_FX = MAG_W'(32'sh0200_0000);

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      DONE
   } state_t;

   // Full-width signed product, arithmetically shifted (truncates toward -inf).
   function automatic logic signed [PROD_W-1:0] fx_mul_shift(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b,
      input int unsigned              sh
   );
      logic signed [PROD_W-1:0] p;
      p = PROD_W'(a) * PROD_W'(b);
      return p >>> sh;
   endfunction

   function automatic logic [23:0] color_map(input logic [7:0] count);
      logic [7:0] sq;
      logic [7:0] cube;
      sq   = count * count;
      cube = sq * count;
      return {sq, cube, count};
   endfunction

   function automatic logic signed [DATA_W-1:0] fx_from_real(input real r);
      return DATA_W'($rtoi(r * real'(longint'(1) << FRAC_W)));
   endfunction

endpackage

// File: rtl/mandel_iter_core_if.sv
// Coordinate-in / result-out handshake bundle for mandel_iter_core.
// MANDEL_COLOR_MAP_EN adds the m_rgb colour output.
interface mandel_iter_core_if #(
   parameter int unsigned USER_W = 2,
   parameter int unsigned CNT_W  = 8
) ();

   logic                                s_valid;
   logic                                s_ready;
   logic signed [mandel_pkg::DATA_W-1:0] s_cr;
   logic signed [mandel_pkg::DATA_W-1:0] s_ci;
   logic [USER_W-1:0]                   s_user;

   logic                                m_valid;
   logic                                m_ready;
   logic [CNT_W-1:0]                    m_count;
   logic [USER_W-1:0]                   m_user;

`ifdef MANDEL_COLOR_MAP_EN
   logic [23:0]                         m_rgb;

   // slave: the core; master: the upstream source / downstream sink pair
   modport slave  (input  s_valid, s_cr, s_ci, s_user, m_ready,
                   output s_ready, m_valid, m_count, m_user, m_rgb);
   modport master (output s_valid, s_cr, s_ci, s_user, m_ready,
                   input  s_ready, m_valid, m_count, m_user, m_rgb);
`else
   modport slave  (input  s_valid, s_cr, s_ci, s_user, m_ready,
                   output s_ready, m_valid, m_count, m_user);
   modport master (output s_valid, s_cr, s_ci, s_user, m_ready,
                   input  s_ready, m_valid, m_count, m_user);
`endif

endinterface

// File: rtl/mandel_step.sv
// Combinational single Mandelbrot iteration: z' = z^2 + c plus the |z|^2 > 4 escape test.
module mandel_step
   import mandel_pkg::*;
(
   input  logic signed [DATA_W-1:0] zr,
   input  logic signed [DATA_W-1:0] zi,
   input  logic signed [DATA_W-1:0] cr,
   input  logic signed [DATA_W-1:0] ci,
   output logic signed [DATA_W-1:0] zr_next,
   output logic signed [DATA_W-1:0] zi_next,
   output logic                     escape
);

   logic signed [PROD_W-1:0] zr2_full;
   logic signed [PROD_W-1:0] zi2_full;
   logic signed [PROD_W-1:0] zri2_full;
   logic signed [MAG_W-1:0]  mag;

   always_comb begin
      zr2_full  = fx_mul_shift(zr, zr, FRAC_W);
      zi2_full  = fx_mul_shift(zi, zi, FRAC_W);
      zri2_full = fx_mul_shift(zr, zi, FRAC_W - 1);
      // Squares kept wide for the compare: a just-updated z can reach |z|~8,
      // whose square would wrap in Q4.23 and hide the escape.
      mag       = MAG_W'(zr2_full) + MAG_W'(zi2_full);
      escape    = mag > FOUR_FX;
      zr_next   = DATA_W'(zr2_full - zi2_full) + cr;
      zi_next   = DATA_W'(zri2_full) + ci;
   end

endmodule

// File: rtl/mandel_iter_core.sv
// Fixed-point Mandelbrot escape-time engine: one pixel in flight, one iteration per cycle.
// Define MANDEL_COLOR_MAP_EN to add the registered m_rgb colour output.
module mandel_iter_core
   import mandel_pkg::*;
#(
   parameter int unsigned MAX_ITER = 255,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned USER_W   = 2
) (
   input  logic              aclk,
   input  logic              aresetn,
   mandel_iter_core_if.slave bus
);

   state_t                   state_q;
   state_t                   state_d;
   logic signed [DATA_W-1:0] cr_q;
   logic signed [DATA_W-1:0] ci_q;
   logic signed [DATA_W-1:0] zr_q;
   logic signed [DATA_W-1:0] zi_q;
   logic signed [DATA_W-1:0] zr_nx;
   logic signed [DATA_W-1:0] zi_nx;
   logic [USER_W-1:0]        user_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [CNT_W-1:0]         cnt_inc;
   logic [CNT_W-1:0]         count_d;
   logic [CNT_W-1:0]         count_q;
   logic                     escape;
   logic                     finish;
   logic                     s_ready_q;
   logic                     m_valid_q;
   logic                     accept;
   logic                     handoff;

   mandel_step u_step (
      .zr      (zr_q),
      .zi      (zi_q),
      .cr      (cr_q),
      .ci      (ci_q),
      .zr_next (zr_nx),
      .zi_next (zi_nx),
      .escape  (escape)
   );

   assign cnt_inc = cnt_q + CNT_W'(1);
   assign finish  = escape || (cnt_inc == CNT_W'(MAX_ITER));
   assign accept  = bus.s_valid && s_ready_q;
   assign handoff = m_valid_q && bus.m_ready;

   always_comb begin
      state_d = state_q;
      count_d = escape ? cnt_q : cnt_inc;
      unique case (state_q)
         IDLE:    if (accept)  state_d = ITER;
         ITER:    if (finish)  state_d = DONE;
         DONE:    if (handoff) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake flags are registered from next state so they stay low through reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         count_q   <= '0;
         user_q    <= '0;
         cnt_q     <= '0;
         zr_q      <= '0;
         zi_q      <= '0;
         cr_q      <= '0;
         ci_q      <= '0;
      end else begin
         state_q   <= state_d;
         s_ready_q <= (state_d == IDLE);
         m_valid_q <= (state_d == DONE);
         case (state_q)
            IDLE: begin
               if (accept) begin
                  cr_q   <= bus.s_cr;
                  ci_q   <= bus.s_ci;
                  user_q <= bus.s_user;
                  zr_q   <= '0;
                  zi_q   <= '0;
                  cnt_q  <= '0;
               end
            end
            ITER: begin
               zr_q  <= zr_nx;
               zi_q  <= zi_nx;
               cnt_q <= cnt_inc;
               if (finish) count_q <= count_d;
            end
            default: ;
         endcase
      end
   end

`ifdef MANDEL_COLOR_MAP_EN
   logic [23:0] rgb_q;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rgb_q <= '0;
      end else if (state_q == ITER && finish) begin
         rgb_q <= color_map(count_d[7:0]);
      end
   end

   assign bus.m_rgb = rgb_q;
`endif

   assign bus.s_ready = s_ready_q;
   assign bus.m_valid = m_valid_q;
   assign bus.m_count = count_q;
   assign bus.m_user  = user_q;

endmodule

// File: tb/tb_mandel_iter_core.sv
// Scoreboard bench for mandel_iter_core: directed and random coordinates against an
// integer escape-time model, with a negedge monitor checking results, latency and handshakes.
module tb_mandel_iter_core;
   import mandel_pkg::*;

   localparam int MAX_ITER = 255;
   localparam int HALF     = 5;

   typedef struct {
      int         count;
      logic [1:0] user;
      int         acc;
      int         hold;
   } exp_t;

   logic aclk = 1'b0;
   logic aresetn;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];
   exp_t cur;
   bit   active = 1'b0;
   bit   hs_pending = 1'b0;
   int   hold_left = 0;

   mandel_iter_core_if #(.USER_W(2), .CNT_W(8)) bus ();

   mandel_iter_core #(.MAX_ITER(MAX_ITER), .CNT_W(8), .USER_W(2)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   always #HALF aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Escape-time count straight from the iteration rules, in 64-bit integers.
   function automatic int ref_count(input longint cr, input longint ci);
      longint zr = 0;
      longint zi = 0;
      longint zr2, zi2, zr_new;
      for (int k = 0; k < MAX_ITER; k++) begin
         zr2 = (zr * zr) >>> FRAC_W;
         zi2 = (zi * zi) >>> FRAC_W;
         if (zr2 + zi2 > (longint'(4) <<< FRAC_W)) return k;
         zr_new = zr2 - zi2 + cr;
         zi     = ((zr * zi) >>> (FRAC_W - 1)) + ci;
         zr     = zr_new;
      end
      return MAX_ITER;
   endfunction

`ifdef MANDEL_COLOR_MAP_EN
   function automatic int ref_rgb(input int c);
      return (((c * c) % 256) << 16) | (((c * c * c) % 256) << 8) | (c % 256);
   endfunction
`endif

   task automatic send(input logic signed [DATA_W-1:0] cr, input logic signed [DATA_W-1:0] ci,
                       input logic [1:0] user, input int hold);
      exp_t e;
      int   n = 0;
      @(negedge aclk);
      bus.s_valid = 1'b1;
      bus.s_cr    = cr;
      bus.s_ci    = ci;
      bus.s_user  = user;
      while (!bus.s_ready && n < 1000) begin
         @(negedge aclk);
         n++;
      end
      if (!bus.s_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: s_ready stayed %0b, required 1", bus.s_ready);
         bus.s_valid = 1'b0;
         return;
      end
      e.count = ref_count(cr, ci);
      e.user  = user;
      e.acc   = cyc + 1;
      e.hold  = hold;
      exp_q.push_back(e);
      @(posedge aclk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_cr    = DATA_W'($urandom);
      bus.s_ci    = DATA_W'($urandom);
      bus.s_user  = 2'($urandom);
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || active) && n < limit) begin
         @(negedge aclk);
         n++;
      end
      if (exp_q.size() != 0 || active) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      end
   endtask

   // Monitor: pops the scoreboard on each new result and drives m_ready.
   initial begin
      bus.m_ready = 1'b0;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            active      = 1'b0;
            hs_pending  = 1'b0;
            bus.m_ready = 1'b0;
            continue;
         end
         if (hs_pending) begin
            check("s_ready_after_handshake", bus.s_ready, 1);
            check("m_valid_after_handshake", bus.m_valid, 0);
            hs_pending = 1'b0;
         end
         if (bus.m_valid) begin
            if (!active) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_result: m_count=%0d with empty scoreboard", bus.m_count);
                  bus.m_ready = 1'b1;
                  continue;
               end
               cur       = exp_q.pop_front();
               active    = 1'b1;
               hold_left = cur.hold;
               check("m_count", bus.m_count, cur.count);
               check("m_user", bus.m_user, cur.user);
               check("latency", cyc - cur.acc, (cur.count < MAX_ITER) ? cur.count + 1 : MAX_ITER);
               check("s_ready_while_done", bus.s_ready, 0);
`ifdef MANDEL_COLOR_MAP_EN
               check("m_rgb", bus.m_rgb, ref_rgb(cur.count));
`endif
            end else begin
               check("held_m_count", bus.m_count, cur.count);
               check("held_m_user", bus.m_user, cur.user);
               check("held_s_ready", bus.s_ready, 0);
            end
            if (hold_left > 0) begin
               bus.m_ready = 1'b0;
               hold_left--;
            end else begin
               bus.m_ready = (cur.hold > 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            hs_pending = bus.m_ready;
         end else begin
            active      = 1'b0;
            bus.m_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin
      int r;
      int rin;
      logic signed [DATA_W-1:0] rcr, rci;
      aresetn     = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_cr    = '0;
      bus.s_ci    = '0;
      bus.s_user  = '0;
      repeat (3) @(negedge aclk);
      check("reset_s_ready", bus.s_ready, 0);
      check("reset_m_valid", bus.m_valid, 0);
      check("reset_m_count", bus.m_count, 0);
      check("reset_m_user", bus.m_user, 0);
`ifdef MANDEL_COLOR_MAP_EN
      check("reset_m_rgb", bus.m_rgb, 0);
`endif
      aresetn = 1'b1;
      @(negedge aclk);
      check("s_ready_after_reset", bus.s_ready, 1);

      send(fx_from_real(0.0), fx_from_real(0.0), 2'b01, 0);
      send(fx_from_real(2.0), fx_from_real(0.0), 2'b10, 0);
      send(fx_from_real(-2.5), fx_from_real(0.0), 2'b11, 0);
      send(fx_from_real(1.5), fx_from_real(1.5), 2'b00, 0);
      send(fx_from_real(2.0), fx_from_real(0.0), 2'b11, 20);
      send(fx_from_real(-0.75), fx_from_real(0.1), 2'b01, 0);
      send(fx_from_real(0.3), fx_from_real(0.6), 2'b00, 0);
      send(fx_from_real(-1.8), fx_from_real(0.05), 2'b10, 0);

      r   = 32'h0180_0000;
      rin = 32'h0100_0000;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge aclk);
         if (i % 2 == 0) begin
            rcr = DATA_W'(int'($urandom_range(0, 2 * r)) - r);
            rci = DATA_W'(int'($urandom_range(0, 2 * r)) - r);
         end else begin
            rcr = DATA_W'(int'($urandom_range(0, 2 * rin)) - rin);
            rci = DATA_W'(int'($urandom_range(0, 2 * rin)) - rin);
         end
         send(rcr, rci, 2'($urandom), 0);
      end
      drain(2000);

      send(fx_from_real(0.0), fx_from_real(0.0), 2'b01, 0);
      repeat (49) @(negedge aclk);
      aresetn = 1'b0;
      @(negedge aclk);
      check("midreset_m_valid", bus.m_valid, 0);
      check("midreset_s_ready", bus.s_ready, 0);
      check("midreset_m_count", bus.m_count, 0);
      check("midreset_m_user", bus.m_user, 0);
      exp_q.delete();
      aresetn = 1'b1;
      @(negedge aclk);
      check("s_ready_after_midreset", bus.s_ready, 1);
      send(fx_from_real(2.0), fx_from_real(0.0), 2'b10, 0);
      drain(2000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
